// File: rtl/wb_ddr2_pkg.sv
// Shared types and constants for the two-master Wishbone to DDR2 arbiter.
package wb_ddr2_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 64;
  localparam int unsigned SEL_W = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] GntIdle = 2'b00;
  localparam logic [1:0] GntM0   = 2'b01;
  localparam logic [1:0] GntM1   = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic             cyc;
    logic             stb;
    logic             we;
  } wb_req_t;

  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } wb_rsp_t;

endpackage

// File: rtl/wb_arb_mux2.sv
// Grant-qualified slave request mux and per-master termination demux (combinational only).
module wb_arb_mux2
  import wb_ddr2_pkg::*;
(
  input  logic [1:0] i_gnt,
  input  wb_req_t    i_m0_req,
  input  wb_req_t    i_m1_req,
  output wb_req_t    o_s_req,
  input  wb_rsp_t    i_s_rsp,
  input  logic       i_wd_err,
  output wb_rsp_t    o_m0_rsp,
  output wb_rsp_t    o_m1_rsp
);

  wb_rsp_t w_rsp;

  always_comb begin
    o_s_req = '0;
    unique case (i_gnt)
      GntM0:   o_s_req = i_m0_req;
      GntM1:   o_s_req = i_m1_req;
      default: o_s_req = '0;
    endcase
  end

  // Watchdog error is merged into the granted master's err line.
  always_comb begin
    w_rsp     = i_s_rsp;
    w_rsp.err = i_s_rsp.err | i_wd_err;
    o_m0_rsp  = i_gnt[0] ? w_rsp : '0;
    o_m1_rsp  = i_gnt[1] ? w_rsp : '0;
  end

endmodule

// File: rtl/wb_ddr2_arb.sv
// Two-master Wishbone arbiter (m0 high priority, m1 starvation-guarded) to one DDR2 port.
// Optional bus watchdog built when ARB_TIMEOUT_EN is defined.
module wb_ddr2_arb
  import wb_ddr2_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [2:0]       m0_cti_i,
  input  logic [1:0]       m0_bte_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_rty_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [2:0]       m1_cti_i,
  input  logic [1:0]       m1_bte_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_rty_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [2:0]       s_cti_o,
  output logic [1:0]       s_bte_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [1:0]       gnt_o,
  output logic             timeout_o
);

  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

  if (STARVE_LIMIT == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("wb_ddr2_arb: STARVE_LIMIT and TIMEOUT_CYCLES must be non-zero");
  end

  arb_state_e       r_state;
  logic [1:0]       r_gnt;
  logic [WaitW-1:0] r_wait_cnt;
  logic             w_pick_m1;
  logic             w_wd_fire;
  wb_req_t          w_m0_req;
  wb_req_t          w_m1_req;
  wb_req_t          w_s_req;
  wb_rsp_t          w_s_rsp;
  wb_rsp_t          w_m0_rsp;
  wb_rsp_t          w_m1_rsp;

  // m1 wins an idle arbitration when alone or once it has waited STARVE_LIMIT cycles.
  assign w_pick_m1 = m1_cyc_i && (!m0_cyc_i || (r_wait_cnt == WaitMax));

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= StIdle;
      r_gnt   <= GntIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_pick_m1) begin
            r_state <= StGnt1;
            r_gnt   <= GntM1;
          end else if (m0_cyc_i) begin
            r_state <= StGnt0;
            r_gnt   <= GntM0;
          end
        end
        StGnt0: begin
          if (!m0_cyc_i) begin
            r_state <= StIdle;
            r_gnt   <= GntIdle;
          end
        end
        StGnt1: begin
          if (!m1_cyc_i) begin
            r_state <= StIdle;
            r_gnt   <= GntIdle;
          end
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= GntIdle;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wait_cnt <= '0;
    end else if (!m1_cyc_i || (r_state == StIdle && w_pick_m1)) begin
      r_wait_cnt <= '0;
    end else if (r_state != StGnt1 && r_wait_cnt != WaitMax) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  logic [WdogW-1:0] r_wdog;
  logic             r_timeout;
  logic             w_s_term;

  assign w_s_term  = s_ack_i | s_err_i | s_rty_i;
  // Fires during the TIMEOUT_CYCLES-th unterminated strobe cycle.
  assign w_wd_fire = (r_state != StIdle) && s_stb_o && !w_s_term && (r_wdog == WdogLast);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == StIdle || w_s_term || w_wd_fire) begin
        r_wdog <= '0;
      end else if (s_stb_o) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_wd_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_wd_fire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign w_m0_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, cti: m0_cti_i,
                      bte: m0_bte_i, cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i};
  assign w_m1_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, cti: m1_cti_i,
                      bte: m1_bte_i, cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i};
  assign w_s_rsp  = '{ack: s_ack_i, err: s_err_i, rty: s_rty_i};

  wb_arb_mux2 u_mux (
    .i_gnt    (r_gnt),
    .i_m0_req (w_m0_req),
    .i_m1_req (w_m1_req),
    .o_s_req  (w_s_req),
    .i_s_rsp  (w_s_rsp),
    .i_wd_err (w_wd_fire),
    .o_m0_rsp (w_m0_rsp),
    .o_m1_rsp (w_m1_rsp)
  );

  assign s_adr_o  = w_s_req.adr;
  assign s_dat_o  = w_s_req.dat;
  assign s_sel_o  = w_s_req.sel;
  assign s_cti_o  = w_s_req.cti;
  assign s_bte_o  = w_s_req.bte;
  assign s_cyc_o  = w_s_req.cyc;
  assign s_stb_o  = w_s_req.stb;
  assign s_we_o   = w_s_req.we;

  assign m0_ack_o = w_m0_rsp.ack;
  assign m0_err_o = w_m0_rsp.err;
  assign m0_rty_o = w_m0_rsp.rty;
  assign m1_ack_o = w_m1_rsp.ack;
  assign m1_err_o = w_m1_rsp.err;
  assign m1_rty_o = w_m1_rsp.rty;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = r_gnt;

endmodule

// File: tb/tb_wb_ddr2_arb.sv
// Directed self-checking bench for wb_ddr2_arb (STARVE_LIMIT 64, TIMEOUT_CYCLES 16).
module tb_wb_ddr2_arb;
  import wb_ddr2_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  logic             wb_clk;
  logic             wb_rst_n;
  logic [31:0]      m0_adr_i, m1_adr_i;
  logic [63:0]      m0_dat_i, m1_dat_i;
  logic [7:0]       m0_sel_i, m1_sel_i;
  logic [2:0]       m0_cti_i, m1_cti_i;
  logic [1:0]       m0_bte_i, m1_bte_i;
  logic             m0_cyc_i, m0_stb_i, m0_we_i;
  logic             m1_cyc_i, m1_stb_i, m1_we_i;
  logic             m0_ack_o, m0_err_o, m0_rty_o;
  logic             m1_ack_o, m1_err_o, m1_rty_o;
  logic [63:0]      m0_dat_o, m1_dat_o;
  logic [31:0]      s_adr_o;
  logic [63:0]      s_dat_o;
  logic [7:0]       s_sel_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [63:0]      s_dat_i;
  logic             s_ack_i, s_err_i, s_rty_i;
  logic [1:0]       gnt_o;
  logic             timeout_o;

  int n_chk = 0;
  int n_err = 0;

  wb_ddr2_arb #(
    .STARVE_LIMIT   (64),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .m0_adr_i  (m0_adr_i),
    .m0_dat_i  (m0_dat_i),
    .m0_sel_i  (m0_sel_i),
    .m0_cti_i  (m0_cti_i),
    .m0_bte_i  (m0_bte_i),
    .m0_cyc_i  (m0_cyc_i),
    .m0_stb_i  (m0_stb_i),
    .m0_we_i   (m0_we_i),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m0_rty_o  (m0_rty_o),
    .m0_dat_o  (m0_dat_o),
    .m1_adr_i  (m1_adr_i),
    .m1_dat_i  (m1_dat_i),
    .m1_sel_i  (m1_sel_i),
    .m1_cti_i  (m1_cti_i),
    .m1_bte_i  (m1_bte_i),
    .m1_cyc_i  (m1_cyc_i),
    .m1_stb_i  (m1_stb_i),
    .m1_we_i   (m1_we_i),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .m1_rty_o  (m1_rty_o),
    .m1_dat_o  (m1_dat_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_cti_o   (s_cti_o),
    .s_bte_o   (s_bte_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_rty_i   (s_rty_i),
    .gnt_o     (gnt_o),
    .timeout_o (timeout_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_adr;

    wb_rst_n = 1'b0;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_cti_i = CTI_CLASSIC; m0_bte_i = '0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_cti_i = CTI_CLASSIC; m1_bte_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    s_dat_i = 64'h0123_4567_89ab_cdef; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge wb_clk);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 1'b0);
    chk("rst_sstb", s_stb_o, 1'b0);
    chk("rst_swe", s_we_o, 1'b0);
    chk("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    chk("rst_timeout", timeout_o, 1'b0);
    tick();
    wb_rst_n = 1'b1;

    // Single m1 classic write
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 8'hff;
    m1_adr_i = 32'h0003_c000; m1_dat_i = 64'h00ff_0000_00ff_0000;
    @(negedge wb_clk);
    chk("t1_latency_gnt", gnt_o, 2'b00);
    chk("t1_latency_scyc", s_cyc_o, 1'b0);
    tick();
    s_ack_i = 1'b1;
    @(negedge wb_clk);
    chk("t1_gnt", gnt_o, 2'b10);
    chk("t1_sadr", s_adr_o, 32'h0003_c000);
    chk("t1_sdat", s_dat_o, 64'h00ff_0000_00ff_0000);
    chk("t1_swe", s_we_o, 1'b1);
    chk("t1_m1ack", m1_ack_o, 1'b1);
    chk("t1_m0ack", m0_ack_o, 1'b0);
    chk("t1_rdata", m1_dat_o, 64'h0123_4567_89ab_cdef);
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; s_ack_i = 1'b0;
    @(negedge wb_clk);
    chk("t1_drop_scyc", s_cyc_o, 1'b0);
    tick();
    @(negedge wb_clk);
    chk("t1_idle_gnt", gnt_o, 2'b00);

    // Simultaneous request with wait_cnt at 0
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h200;
    tick();
    s_ack_i = 1'b1;
    @(negedge wb_clk);
    chk("t2_gnt0", gnt_o, 2'b01);
    chk("t2_sadr", s_adr_o, 32'h100);
    chk("t2_m0ack", m0_ack_o, 1'b1);
    chk("t2_m1ack", m1_ack_o, 1'b0);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    tick();
    @(negedge wb_clk);
    chk("t2_dead_cycle", gnt_o, 2'b00);
    tick();
    @(negedge wb_clk);
    chk("t2_gnt1", gnt_o, 2'b10);
    chk("t2_sadr1", s_adr_o, 32'h200);
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();

    // 8-beat incrementing burst on m0 while m1 waits
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'hdead_0000;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_adr  = 32'h1000 + 32'(8 * i);
      m0_adr_i = exp_adr;
      m0_cti_i = (i == 7) ? CTI_EOB : CTI_INC;
      s_ack_i  = 1'b1;
      @(negedge wb_clk);
      chk($sformatf("t3_gnt_b%0d", i), gnt_o, 2'b01);
      chk($sformatf("t3_sadr_b%0d", i), s_adr_o, exp_adr);
      chk($sformatf("t3_acks_b%0d", i), {m0_ack_o, m1_ack_o}, 2'b10);
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = CTI_CLASSIC; s_ack_i = 1'b0;
    tick();
    tick();
    @(negedge wb_clk);
    chk("t3_then_m1", gnt_o, 2'b10);
    chk("t3_m1_sadr", s_adr_o, 32'hdead_0000);
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    tick();

    // Starvation guard: m0 back-to-back cycles, m1 held requesting
    m0_cyc_i = 1'b1;
    m1_cyc_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    m0_cyc_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1;
    tick();
    @(negedge wb_clk);
    chk("t4_early_m0", gnt_o, 2'b01);
    for (int i = 0; i < 70; i++) tick();
    m0_cyc_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1;
    @(negedge wb_clk);
    chk("t4_idle_between", gnt_o, 2'b00);
    tick();
    @(negedge wb_clk);
    chk("t4_starved_m1", gnt_o, 2'b10);
    chk("t4_wait_cleared", dut.r_wait_cnt, 0);
    tick();
    m1_cyc_i = 1'b0;
    tick();
    m0_cyc_i = 1'b0;
    tick();
    tick();

    // Reset asserted during beat 3 of an m0 burst
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = CTI_INC; m0_adr_i = 32'h2000;
    tick();
    s_ack_i = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      m0_adr_i = 32'h2000 + 32'(8 * i);
    end
    tick();
    m0_adr_i = 32'h2018;
    #1;
    wb_rst_n = 1'b0;
    #1;
    chk("t5_rst_scyc", s_cyc_o, 1'b0);
    chk("t5_rst_sstb", s_stb_o, 1'b0);
    chk("t5_rst_gnt", gnt_o, 2'b00);
    chk("t5_rst_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    tick();
    s_ack_i = 1'b0;
    m0_cti_i = CTI_CLASSIC;
    tick();
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    chk("t5_after_rel_idle", gnt_o, 2'b00);
    tick();
    @(negedge wb_clk);
    chk("t5_regrant", gnt_o, 2'b01);
    chk("t5_regrant_scyc", s_cyc_o, 1'b1);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    tick();

    // Stalled slave: watchdog error pulse on stb-cycle 16 when built in
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h4000;
    tick();
    for (int k = 1; k <= 20; k++) begin
      @(negedge wb_clk);
      chk($sformatf("t6_err_c%0d", k), m0_err_o, WdOn && (k == 16));
      chk($sformatf("t6_to_c%0d", k), timeout_o, WdOn && (k > 16));
      chk($sformatf("t6_m1err_c%0d", k), m1_err_o, 1'b0);
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    tick();
    @(negedge wb_clk);
    chk("t6_timeout_sticky", timeout_o, WdOn);
    chk("t6_idle_gnt", gnt_o, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_ddr2_arb.md
Name: wb_ddr2_arb

Overview:
- Two-master Wishbone arbiter sharing one 64-bit DDR2 controller port.
- Master 0 is the VGA scan-out reader and has high priority. Master 1 is the frame-fill engine or CPU and has low priority.
- The grant is held for the whole bus cycle (cyc high), so classic and incrementing bursts are never split.
- A starvation guard guarantees master 1 forward progress while video traffic is continuous.

Parameters:
- STARVE_LIMIT, 64: number of cycles master 1 may wait while requesting before it wins the next arbitration.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- wb_clk  input  1  system clock; all logic on the rising edge.
- wb_rst_n  input  1  asynchronous active-low reset.
- m0_adr_i / m1_adr_i  input  32 each  master byte address.
- m0_dat_i / m1_dat_i  input  64 each  master write data.
- m0_sel_i / m1_sel_i  input  8 each  byte selects.
- m0_cti_i / m1_cti_i  input  3 each  cycle type.
- m0_bte_i / m1_bte_i  input  2 each  burst type.
- m0_cyc_i, m0_stb_i, m0_we_i / m1_cyc_i, m1_stb_i, m1_we_i  input  1 each  master bus controls.
- m0_ack_o, m0_err_o, m0_rty_o / m1_ack_o, m1_err_o, m1_rty_o  output  1 each  per-master termination.
- m0_dat_o / m1_dat_o  output  64 each  read data.
- s_adr_o 32, s_dat_o 64, s_sel_o 8, s_cti_o 3, s_bte_o 2, s_cyc_o 1, s_stb_o 1, s_we_o 1  output  slave side, toward the DDR2 controller.
- s_dat_i 64, s_ack_i 1, s_err_i 1, s_rty_i 1  input  slave responses.
- gnt_o  output  2  one-hot current grant; 00 when idle.
- timeout_o  output  1  sticky watchdog flag.

Behaviour:
- State machine states: IDLE, GNT0, GNT1. State is registered.
- Reset (asynchronous, wb_rst_n = 0):
  - State goes to IDLE, wait_cnt = 0, timeout_o = 0, gnt_o = 00.
  - All s_* control outputs are 0, so s_cyc_o, s_stb_o and s_we_o are low.
  - All m*_ack/err/rty_o are 0.
  - Reset asserted mid-cycle abandons the transfer. No response is generated.
- IDLE arbitration, evaluated on cycle N:
  - m0_cyc_i only: go to GNT0.
  - m1_cyc_i only: go to GNT1.
  - Both requesting: go to GNT1 if wait_cnt == STARVE_LIMIT, otherwise GNT0.
  - Neither requesting: stay in IDLE.
  - Arbitration latency is 1 cycle: the slave sees s_cyc_o at cycle N+1 at the earliest.
- Granted state (GNTk):
  - s_* outputs are combinationally muxed from master k and qualified by the grant. Outside a grant, s_cyc_o and s_stb_o are forced to 0.
  - s_ack_i, s_err_i and s_rty_i route only to master k. The non-granted master's terminations are held at 0.
  - s_dat_i is broadcast to both m*_dat_o unregistered.
- Release:
  - When mk_cyc_i is sampled low in GNTk, return to IDLE.
  - This costs one dead cycle between grants, even if the other master is waiting.
  - The grant is never revoked while cyc is high, whatever the cti value (burst lock).
- wait_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments each cycle that m1_cyc_i = 1 and state != GNT1.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on entry to GNT1 and whenever m1_cyc_i = 0.
- gnt_o: 01 in GNT0, 10 in GNT1, 00 in IDLE.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in GNTk while s_stb_o = 1 and no slave termination is seen.
  - It is cleared by any ack, err or rty, and in IDLE.
  - On reaching TIMEOUT_CYCLES: mk_err_o pulses for exactly one cycle, the counter clears, and timeout_o sets. timeout_o stays set until reset.
  - The grant is held until the master drops cyc.
- Not defined: no counter is built, and timeout_o is tied to 0.

Decomposition:
- Shared package wb_ddr2_pkg holds:
  - the state encoding (IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2);
  - the cti constants CTI_CLASSIC = 3'b000, CTI_INC = 3'b010, CTI_EOB = 3'b111;
  - the bus widths ADR_W = 32, DAT_W = 64, SEL_W = 8.
- One sub-module: wb_arb_mux2, the purely combinational grant-qualified slave mux and response demux.
- The FSM, wait_cnt and watchdog stay at top level.

Test Plan:
- Single m1 write: m1 asserts a classic write with adr = 0x3c000, dat = 0x00ff000000ff0000 -> grant in 1 cycle; s_adr_o = 0x3c000; m1_ack_o follows s_ack_i; m0_ack_o stays 0.
- Simultaneous request: both cyc rise on the same cycle with wait_cnt = 0 -> gnt_o = 01; m1 is granted only after m0 drops cyc plus 1 IDLE cycle.
- Burst lock: m0 runs an 8-beat incrementing burst (cti 010 ×7, then 111) while m1 requests -> gnt_o = 01 for all 8 acks; no s_adr_o from m1 appears mid-burst.
- Starvation: m0 issues back-to-back cycles with m1 held requesting for 64 cycles -> the next IDLE grants m1 (gnt_o = 10) and wait_cnt returns to 0.
- Reset mid-burst: deassert wb_rst_n during beat 3 -> s_cyc_o, s_stb_o, gnt_o and all acks go 0 immediately; after release, arbitration restarts from IDLE.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16: slave never acks -> m0_err_o is high for exactly 1 cycle at stb-cycle 16, and timeout_o stays 1.
